// File: rtl/bcd_pkg.sv
// Shared BCD display-bus definitions.
// Used by both the bus driver and the receive-side demultiplexer.
package bcd_pkg;

    localparam int BCD_WIDTH = 4;
    localparam logic [BCD_WIDTH-1:0] BCD_MAX = 4'd9;

    // What a settled {sel,data} pair means to the receiver.
    typedef enum logic [1:0] {
        SC_IDLE  = 2'd0,
        SC_MULTI = 2'd1,
        SC_BAD   = 2'd2,
        SC_DIGIT = 2'd3
    } settle_class_e;

    // Ceiling log2 with a floor of one bit, so the result is
    // always usable as a vector width.
    function automatic int clogb2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_settle_detect.sv
// Input register and dwell filter for the multiplexed BCD bus.
// Emits one strobe per stable dwell plus the {sel,data} that settled.
module bcd_settle_detect
    import bcd_pkg::*;
#(
    parameter int DISPLAYS_NUM  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [BCD_WIDTH-1:0]    i_bcd_muxed,
    input  logic [DISPLAYS_NUM-1:0] i_bcd_sel,
    output logic                    o_settle,
    output logic [DISPLAYS_NUM-1:0] o_sel,
    output logic [BCD_WIDTH-1:0]    o_data
);

    localparam int RUN_W = clogb2(SETTLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SETTLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [DISPLAYS_NUM-1:0] sel_q;
    logic [BCD_WIDTH-1:0]    data_q;
    logic [RUN_W-1:0]        run_q;
    logic [RUN_W-1:0]        run_nxt;
    logic                    same;
    logic                    fire;

    // Run length of the value about to be registered; saturates so a
    // long dwell can only ever fire once.
    always_comb begin
        same    = (i_bcd_sel == sel_q) && (i_bcd_muxed == data_q);
        run_nxt = RUN_ONE;
        fire    = 1'b0;
        if (same) begin
            if (run_q == RUN_MAX) begin
                run_nxt = run_q;
            end else begin
                run_nxt = run_q + RUN_ONE;
            end
        end
        fire = (run_nxt == RUN_MAX) && (!same || (run_q != RUN_MAX));
    end

    // Stage-1 register, run counter and settled snapshot.
    // The incoming value equals the registered one whenever fire is set
    // (or is the fresh value when SETTLE_CYCLES is 1), so it is captured.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_q    <= '0;
            data_q   <= '0;
            run_q    <= '0;
            o_settle <= 1'b0;
            o_sel    <= '0;
            o_data   <= '0;
        end else begin
            sel_q    <= i_bcd_sel;
            data_q   <= i_bcd_muxed;
            run_q    <= run_nxt;
            o_settle <= fire;
            if (fire) begin
                o_sel  <= i_bcd_sel;
                o_data <= i_bcd_muxed;
            end
        end
    end

endmodule

// File: rtl/bcd_demux.sv
// Receive side of the multiplexed BCD display bus.
// Rebuilds the parallel digit word and flags malformed dwells.
module bcd_demux
    import bcd_pkg::*;
#(
    parameter int DISPLAYS_NUM  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [BCD_WIDTH-1:0]              i_bcd_muxed,
    input  logic [DISPLAYS_NUM-1:0]           i_bcd_sel,
    output logic [DISPLAYS_NUM*BCD_WIDTH-1:0] o_bcd_data,
    output logic                              o_frame_valid,
    output logic                              o_data_ready,
    output logic                              o_sel_err,
    output logic                              o_digit_err
);

    localparam int IDX_W = clogb2(DISPLAYS_NUM);
    localparam int WORD_W = DISPLAYS_NUM * BCD_WIDTH;

    logic                    set_stb;
    logic [DISPLAYS_NUM-1:0] set_sel;
    logic [BCD_WIDTH-1:0]    set_data;

    logic [BCD_WIDTH-1:0]    shadow_q [DISPLAYS_NUM];
    logic [DISPLAYS_NUM-1:0] seen_q;

    settle_class_e           cls;
    logic                    multi;
    logic                    one_hot;
    logic [IDX_W-1:0]        idx;
    logic                    capture;
    logic [DISPLAYS_NUM-1:0] seen_nxt;
    logic                    complete;
    logic [WORD_W-1:0]       word_nxt;

    bcd_settle_detect #(
        .DISPLAYS_NUM  (DISPLAYS_NUM),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_bcd_muxed (i_bcd_muxed),
        .i_bcd_sel   (i_bcd_sel),
        .o_settle    (set_stb),
        .o_sel       (set_sel),
        .o_data      (set_data)
    );

    // Classify the settled select and decide whether it completes a frame.
    always_comb begin
        cls      = SC_IDLE;
        idx      = '0;
        multi    = |(set_sel & (set_sel - DISPLAYS_NUM'(1)));
        one_hot  = (set_sel != '0) && !multi;
        capture  = 1'b0;
        seen_nxt = seen_q;
        complete = 1'b0;
        word_nxt = '0;

        unique case (1'b1)
            (set_sel == '0):                  cls = SC_IDLE;
            multi:                            cls = SC_MULTI;
            (one_hot && set_data > BCD_MAX):  cls = SC_BAD;
            (one_hot && set_data <= BCD_MAX): cls = SC_DIGIT;
            default:                          cls = SC_IDLE;
        endcase

        for (int k = 0; k < DISPLAYS_NUM; k++) begin
            if (set_sel[k]) begin
                idx = IDX_W'(k);
            end
        end

        capture = set_stb && (cls == SC_DIGIT);
        if (capture) begin
            seen_nxt = seen_q | set_sel;
        end
        complete = capture && (&seen_nxt);

        // Display 0 sits in the most significant nibble.
        for (int k = 0; k < DISPLAYS_NUM; k++) begin
            if (capture && set_sel[k]) begin
                word_nxt[BCD_WIDTH*(DISPLAYS_NUM-1-k) +: BCD_WIDTH] = set_data;
            end else begin
                word_nxt[BCD_WIDTH*(DISPLAYS_NUM-1-k) +: BCD_WIDTH] = shadow_q[k];
            end
        end
    end

    // Shadow digits and seen mask; a completed frame clears the mask.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DISPLAYS_NUM; k++) begin
                shadow_q[k] <= '0;
            end
            seen_q <= '0;
        end else begin
            if (capture) begin
                shadow_q[idx] <= set_data;
            end
            if (complete) begin
                seen_q <= '0;
            end else begin
                seen_q <= seen_nxt;
            end
        end
    end

    // Registered outputs; the word only moves on a whole frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bcd_data    <= '0;
            o_frame_valid <= 1'b0;
            o_data_ready  <= 1'b0;
            o_sel_err     <= 1'b0;
            o_digit_err   <= 1'b0;
        end else begin
            o_frame_valid <= complete;
            o_sel_err     <= set_stb && (cls == SC_MULTI);
            o_digit_err   <= set_stb && (cls == SC_BAD);
            if (complete) begin
                o_bcd_data   <= word_nxt;
                o_data_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_demux.sv
// Scoreboard bench for bcd_demux: dwell-level reference model,
// directed scans plus randomized bus traffic.
module tb_bcd_demux;

    localparam int N = 4;
    localparam int S = 2;

    localparam int K_FRAME = 0;
    localparam int K_SEL   = 1;
    localparam int K_DIG   = 2;

    typedef struct {
        int          kind;
        logic [15:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_bcd_muxed;
    logic [3:0]  i_bcd_sel;
    logic [15:0] o_bcd_data;
    logic        o_frame_valid;
    logic        o_data_ready;
    logic        o_sel_err;
    logic        o_digit_err;

    int compared = 0;
    int mismatched = 0;

    exp_t        expq[$];
    logic [15:0] last_word = 16'h0;

    int          m_shadow [N];
    int          m_seen;
    bit          m_ready;
    logic [3:0]  prev_sel;
    logic [3:0]  prev_data;
    int          prev_len;

    bcd_demux #(
        .DISPLAYS_NUM  (N),
        .SETTLE_CYCLES (S)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_bcd_muxed   (i_bcd_muxed),
        .i_bcd_sel     (i_bcd_sel),
        .o_bcd_data    (o_bcd_data),
        .o_frame_valid (o_frame_valid),
        .o_data_ready  (o_data_ready),
        .o_sel_err     (o_sel_err),
        .o_digit_err   (o_digit_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) m_shadow[k] = 0;
        m_seen    = 0;
        m_ready   = 1'b0;
        prev_sel  = 4'h0;
        prev_data = 4'h0;
        prev_len  = 0;
    endfunction

    // One stable dwell has been recognised by the receiver.
    function automatic void model_settle(input logic [3:0] sel, input logic [3:0] data);
        exp_t e;
        int   k;
        int   w;
        e.word = 16'h0;
        if ($countones(sel) == 0) return;
        if ($countones(sel) > 1) begin
            e.kind = K_SEL;
            expq.push_back(e);
            return;
        end
        k = $clog2(sel);
        if (data > 9) begin
            e.kind = K_DIG;
            expq.push_back(e);
            return;
        end
        m_shadow[k] = int'(data);
        m_seen = m_seen | (1 << k);
        if (m_seen == (1 << N) - 1) begin
            w = 0;
            for (int j = 0; j < N; j++) w = w * 16 + m_shadow[j];
            e.kind = K_FRAME;
            e.word = 16'(w);
            expq.push_back(e);
            m_seen  = 0;
            m_ready = 1'b1;
        end
    endfunction

    // Hold {sel,data} for len clock edges; identical neighbours merge
    // into one longer dwell.
    task automatic dwell(input logic [3:0] sel, input logic [3:0] data, input int len);
        int old;
        if (sel == prev_sel && data == prev_data) begin
            old = prev_len;
            prev_len = prev_len + len;
        end else begin
            old = 0;
            prev_len = len;
            prev_sel = sel;
            prev_data = data;
        end
        if (old < S && prev_len >= S) model_settle(sel, data);
        i_bcd_sel   = sel;
        i_bcd_muxed = data;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        last_word = 16'h0;
    endtask

    // Monitor: pop an expectation on every DUT event, otherwise the
    // published word must hold.
    always @(negedge clk) begin
        exp_t e;
        int   got_kind;
        if (o_frame_valid || o_sel_err || o_digit_err) begin
            if ($countones({o_frame_valid, o_sel_err, o_digit_err}) > 1) begin
                compared++;
                mismatched++;
                $display("FAIL exclusive_pulses: got %b expected one-hot",
                         {o_frame_valid, o_sel_err, o_digit_err});
            end
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: got fv=%b se=%b de=%b expected none",
                         o_frame_valid, o_sel_err, o_digit_err);
            end else begin
                e = expq.pop_front();
                got_kind = o_frame_valid ? K_FRAME : (o_sel_err ? K_SEL : K_DIG);
                chk("event_kind", got_kind, e.kind);
                if (e.kind == K_FRAME) begin
                    chk("frame_word", o_bcd_data, e.word);
                    chk("ready_on_frame", o_data_ready, 1);
                    last_word = e.word;
                end
            end
        end else begin
            chk("word_hold", o_bcd_data, last_word);
        end
    end

    initial begin
        logic [3:0] rs;
        logic [3:0] rd;
        int         r;

        i_rst       = 1'b1;
        i_bcd_sel   = 4'h0;
        i_bcd_muxed = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;

        chk("rst_data", o_bcd_data, 0);
        chk("rst_fv", o_frame_valid, 0);
        chk("rst_ready", o_data_ready, 0);
        chk("rst_selerr", o_sel_err, 0);
        chk("rst_digerr", o_digit_err, 0);

        // Two clean scans of 1,2,3,4.
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < N; k++) dwell(4'(1 << k), 4'(k + 1), 10);
            chk("ready_after_scan", o_data_ready, 1);
            chk("scan_word", o_bcd_data, 16'h1234);
        end

        // Single-cycle glitch mid-scan.
        dwell(4'b0001, 4'd5, 10);
        dwell(4'b0010, 4'd7, 1);
        dwell(4'b0010, 4'd6, 10);
        dwell(4'b0100, 4'd7, 10);
        dwell(4'b1000, 4'd8, 10);
        chk("glitch_word", o_bcd_data, 16'h5678);

        // Multi-hot select, then idle gap.
        dwell(4'b0011, 4'd0, 5);
        dwell(4'b0000, 4'd0, 5);

        // Bad digit blocks the frame until resent.
        dwell(4'b0001, 4'd1, 8);
        dwell(4'b0010, 4'd2, 8);
        dwell(4'b0100, 4'hA, 8);
        dwell(4'b1000, 4'd4, 8);
        chk("no_frame_on_bad", o_bcd_data, 16'h5678);
        dwell(4'b0100, 4'd3, 8);
        chk("resend_word", o_bcd_data, 16'h1234);

        // Reset after two captured digits.
        dwell(4'b0001, 4'd9, 8);
        dwell(4'b0010, 4'd9, 8);
        dwell(4'b0000, 4'd0, S + 4);
        pulse_reset();
        chk("midrst_data", o_bcd_data, 0);
        chk("midrst_ready", o_data_ready, 0);
        dwell(4'b0100, 4'd1, 8);
        dwell(4'b1000, 4'd2, 8);
        chk("partial_ready", o_data_ready, 0);
        dwell(4'b0001, 4'd3, 8);
        dwell(4'b0010, 4'd4, 8);
        chk("post_rst_word", o_bcd_data, 16'h3412);
        chk("post_rst_ready", o_data_ready, 1);

        // Randomized bus traffic including glitches, merges and errors.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 11));
            if (r <= 5) begin
                rs = 4'(1 << $urandom_range(0, 3));
            end else if (r == 6) begin
                rs = 4'h0;
            end else if (r == 7) begin
                rs = 4'($urandom_range(0, 15));
                while ($countones(rs) < 2) rs = 4'($urandom_range(0, 15));
            end else if (r == 8) begin
                rs = prev_sel;
            end else begin
                rs = 4'(1 << $urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) != 0) begin
                rd = 4'($urandom_range(0, 9));
            end else begin
                rd = 4'($urandom_range(0, 15));
            end
            if (r == 8) rd = prev_data;
            dwell(rs, rd, int'($urandom_range(1, 5)));
        end

        dwell(4'b0000, 4'd0, S + 6);
        chk("queue_drained", expq.size(), 0);
        chk("final_ready", o_data_ready, 32'(m_ready));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
